// File: rtl/rob_multi_commit_pkg.sv
// Shared types for the reorder buffer slice: ticket, writeback request,
// commit record and exception cause encoding.
package rob_multi_commit_pkg;

   localparam int XLEN         = 32;
   localparam int REG_W        = 5;
   localparam int ROB_ENTRIES  = 8;
   localparam int ROB_TW       = $clog2(ROB_ENTRIES);
   localparam int ROB_NUM_WB   = 3;
   localparam int ROB_COMMIT_W = 2;

   typedef logic [ROB_TW-1:0] rob_ticket_t;

   typedef enum logic [2:0] {
      NO_XCPT      = 3'd0,
      ILLEGAL      = 3'd1,
      MISALIGNED   = 3'd2,
      ACCESS_FAULT = 3'd3,
      ECALL        = 3'd4
   } xcpt_e;

   typedef struct packed {
      logic              valid;
      rob_ticket_t       ticket;
      logic [XLEN-1:0]   result;
      logic [REG_W-1:0]  dest;
      logic              reg_rw;
      logic              mem_rw;
      xcpt_e             xcpt;
   } rob_req_t;

   typedef struct packed {
      logic              valid;
      logic [REG_W-1:0]  dest;
      logic [XLEN-1:0]   result;
      logic              reg_rw;
   } rob_commit_t;

endpackage

// File: rtl/rob_multi_commit_fwd_search.sv
// rob_fwd_search: youngest-first search for the closest older in-flight
// producer of a source register.
//  valid/ready/reg_rw  per-entry state bits
//  dest/result         per-entry destination and result
//  read_ptr            oldest entry; ticket = consumer's own ticket
//  rs                  source register (x0 never matches)
//  hit/ready_out/value producer found / producer written back / its result
module rob_fwd_search
   import rob_multi_commit_pkg::*;
#(
   parameter  int NUM_ENTRIES = ROB_ENTRIES,
   localparam int TW          = $clog2(NUM_ENTRIES)
) (
   input  logic [NUM_ENTRIES-1:0] valid,
   input  logic [NUM_ENTRIES-1:0] ready,
   input  logic [NUM_ENTRIES-1:0] reg_rw,
   input  logic [REG_W-1:0]       dest [NUM_ENTRIES],
   input  logic [XLEN-1:0]        result [NUM_ENTRIES],
   input  logic [TW-1:0]          read_ptr,
   input  logic [TW-1:0]          ticket,
   input  logic [REG_W-1:0]       rs,
   output logic                   hit,
   output logic                   ready_out,
   output logic [XLEN-1:0]        value
);

   logic [TW-1:0] older_s;
   logic [TW-1:0] idx_s;

   // Walk from ticket-1 back to read_ptr; the first match is the youngest older producer.
   always_comb begin
      hit       = 1'b0;
      ready_out = 1'b0;
      value     = '0;
      idx_s     = '0;
      // Number of entries strictly older than the consumer (0 when it is the head).
      older_s   = ticket - read_ptr;
      for (int d = 1; d < NUM_ENTRIES; d++) begin
         idx_s = ticket - TW'(d);
         if (!hit && (rs != '0) && (TW'(d) <= older_s) &&
             valid[idx_s] && reg_rw[idx_s] && (dest[idx_s] == rs)) begin
            hit       = 1'b1;
            ready_out = ready[idx_s];
            value     = ready[idx_s] ? result[idx_s] : '0;
         end else begin
            hit = hit;
         end
      end
   end

endmodule

// File: rtl/rob_multi_commit.sv
// rob_multi_commit: reorder buffer with in-order allocation, NUM_WB
// writebacks per cycle, up to COMMIT_W in-order commits per cycle, store
// handshake at the head, flush on head exception and operand forwarding.
//  clk/reset          clock, async active-low reset
//  enable             0 freezes state and gates commit/store/flush outputs
//  alloc_*            allocation request, ready, assigned ticket
//  wb_in              writeback channels (lowest index wins on a clash)
//  commit_*           per-slot commit record
//  st_*               head store request / ack
//  flush_out/xcpt_out head exception pulse and cause
//  count_out          occupancy
//  fwd_*              forwarding lookup for two sources
module rob_multi_commit
   import rob_multi_commit_pkg::*;
#(
   parameter  int NUM_ENTRIES = ROB_ENTRIES,
   parameter  int NUM_WB      = ROB_NUM_WB,
   parameter  int COMMIT_W    = ROB_COMMIT_W,
   localparam int TW          = $clog2(NUM_ENTRIES)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            enable,
   input  logic                            alloc_valid_in,
   input  logic [REG_W-1:0]                alloc_dest_in,
   output logic                            alloc_ready_out,
   output logic [TW-1:0]                   alloc_ticket_out,
   input  rob_req_t                        wb_in [NUM_WB],
   output logic [COMMIT_W-1:0]             commit_valid_out,
   output logic [COMMIT_W-1:0][REG_W-1:0]  commit_dest_out,
   output logic [COMMIT_W-1:0][XLEN-1:0]   commit_result_out,
   output logic [COMMIT_W-1:0]             commit_reg_rw_out,
   output logic                            st_req_out,
   output logic [TW-1:0]                   st_ticket_out,
   input  logic                            st_ack_in,
   output logic                            flush_out,
   output xcpt_e                           xcpt_out,
   output logic [TW:0]                     count_out,
   input  logic [TW-1:0]                   fwd_ticket_in,
   input  logic [REG_W-1:0]                fwd_rs1_in,
   input  logic [REG_W-1:0]                fwd_rs2_in,
   output logic                            fwd_src1_hit_out,
   output logic                            fwd_src1_ready_out,
   output logic [XLEN-1:0]                 fwd_src1_out,
   output logic                            fwd_src2_hit_out,
   output logic                            fwd_src2_ready_out,
   output logic [XLEN-1:0]                 fwd_src2_out
);

   localparam int CW = TW + 1;

   logic [NUM_ENTRIES-1:0] valid_r, ready_r, reg_rw_r, mem_rw_r;
   logic [REG_W-1:0]       dest_r   [NUM_ENTRIES];
   logic [XLEN-1:0]        result_r [NUM_ENTRIES];
   xcpt_e                  xcpt_r   [NUM_ENTRIES];
   logic [TW-1:0]          read_ptr_r, write_ptr_r;
   logic [CW-1:0]          cnt_r;

   logic                   head_done_s, flush_s, st_req_s, alloc_ready_s, alloc_fire_s;
   logic                   chain_s;
   logic [TW-1:0]          slot_idx_s [COMMIT_W];
   rob_commit_t [COMMIT_W-1:0] commit_s;
   logic [CW-1:0]          ncommit_s;
   logic                   wb_hit_s [NUM_ENTRIES];
   rob_req_t               wb_sel_s [NUM_ENTRIES];

   assign head_done_s   = valid_r[read_ptr_r] && ready_r[read_ptr_r];
   assign flush_s       = enable && head_done_s && (xcpt_r[read_ptr_r] != NO_XCPT);
   assign st_req_s      = enable && head_done_s && mem_rw_r[read_ptr_r] &&
                          (xcpt_r[read_ptr_r] == NO_XCPT);
   assign alloc_ready_s = (cnt_r < CW'(NUM_ENTRIES)) && !flush_s;
   assign alloc_fire_s  = enable && alloc_valid_in && alloc_ready_s;

   // Commit group: contiguous ready, exception-free entries from the head; a store only in slot 0 with ack.
   always_comb begin
      commit_s  = '0;
      ncommit_s = '0;
      chain_s   = enable;
      for (int k = 0; k < COMMIT_W; k++) begin
         slot_idx_s[k] = read_ptr_r + TW'(k);
         if (chain_s && valid_r[slot_idx_s[k]] && ready_r[slot_idx_s[k]] &&
             (xcpt_r[slot_idx_s[k]] == NO_XCPT) &&
             (!mem_rw_r[slot_idx_s[k]] || ((k == 0) && st_ack_in))) begin
            commit_s[k].valid  = 1'b1;
            commit_s[k].dest   = dest_r[slot_idx_s[k]];
            commit_s[k].result = result_r[slot_idx_s[k]];
            commit_s[k].reg_rw = reg_rw_r[slot_idx_s[k]];
            ncommit_s          = ncommit_s + CW'(1);
            // A committed store closes the group.
            chain_s            = !mem_rw_r[slot_idx_s[k]];
         end else begin
            chain_s = 1'b0;
         end
      end
   end

   // Per-entry writeback select; scanning high to low lets the lowest channel win.
   always_comb begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
         wb_hit_s[e] = 1'b0;
         wb_sel_s[e] = '0;
         for (int i = NUM_WB - 1; i >= 0; i--) begin
            if (wb_in[i].valid && (wb_in[i].ticket[TW-1:0] == TW'(e))) begin
               wb_hit_s[e] = 1'b1;
               wb_sel_s[e] = wb_in[i];
            end else begin
               wb_hit_s[e] = wb_hit_s[e];
            end
         end
      end
   end

   // Entry state, pointers and occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_r     <= '0;
         ready_r     <= '0;
         reg_rw_r    <= '0;
         mem_rw_r    <= '0;
         read_ptr_r  <= '0;
         write_ptr_r <= '0;
         cnt_r       <= '0;
         for (int e = 0; e < NUM_ENTRIES; e++) begin
            dest_r[e]   <= '0;
            result_r[e] <= '0;
            xcpt_r[e]   <= NO_XCPT;
         end
      end else if (enable) begin
         if (flush_s) begin
            // Discard everything in flight; same-cycle allocs and writebacks are dropped.
            valid_r     <= '0;
            ready_r     <= '0;
            write_ptr_r <= read_ptr_r;
            cnt_r       <= '0;
         end else begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
               if (valid_r[e] && wb_hit_s[e]) begin
                  ready_r[e]  <= 1'b1;
                  result_r[e] <= wb_sel_s[e].result;
                  dest_r[e]   <= wb_sel_s[e].dest;
                  reg_rw_r[e] <= wb_sel_s[e].reg_rw;
                  mem_rw_r[e] <= wb_sel_s[e].mem_rw;
                  xcpt_r[e]   <= wb_sel_s[e].xcpt;
               end
            end
            for (int k = 0; k < COMMIT_W; k++) begin
               if (commit_s[k].valid) begin
                  valid_r[slot_idx_s[k]] <= 1'b0;
                  ready_r[slot_idx_s[k]] <= 1'b0;
               end
            end
            if (alloc_fire_s) begin
               valid_r[write_ptr_r]  <= 1'b1;
               ready_r[write_ptr_r]  <= 1'b0;
               dest_r[write_ptr_r]   <= alloc_dest_in;
               // Presume a register write until writeback says otherwise, so unready producers forward.
               reg_rw_r[write_ptr_r] <= (alloc_dest_in != '0);
               mem_rw_r[write_ptr_r] <= 1'b0;
               xcpt_r[write_ptr_r]   <= NO_XCPT;
               write_ptr_r           <= write_ptr_r + TW'(1);
            end
            read_ptr_r <= read_ptr_r + ncommit_s[TW-1:0];
            cnt_r      <= cnt_r + CW'(alloc_fire_s) - ncommit_s;
         end
      end
   end

   assign alloc_ready_out  = alloc_ready_s;
   assign alloc_ticket_out = write_ptr_r;
   assign st_req_out       = st_req_s;
   assign st_ticket_out    = read_ptr_r;
   assign flush_out        = flush_s;
   assign xcpt_out         = flush_s ? xcpt_r[read_ptr_r] : NO_XCPT;
   assign count_out        = cnt_r;

   // Unpack the commit records onto the flat output ports.
   always_comb begin
      for (int k = 0; k < COMMIT_W; k++) begin
         commit_valid_out[k]  = commit_s[k].valid;
         commit_dest_out[k]   = commit_s[k].dest;
         commit_result_out[k] = commit_s[k].result;
         commit_reg_rw_out[k] = commit_s[k].reg_rw;
      end
   end

   rob_fwd_search #(.NUM_ENTRIES(NUM_ENTRIES)) u_fwd_src1 (
      .valid(valid_r), .ready(ready_r), .reg_rw(reg_rw_r),
      .dest(dest_r), .result(result_r),
      .read_ptr(read_ptr_r), .ticket(fwd_ticket_in), .rs(fwd_rs1_in),
      .hit(fwd_src1_hit_out), .ready_out(fwd_src1_ready_out), .value(fwd_src1_out)
   );

   rob_fwd_search #(.NUM_ENTRIES(NUM_ENTRIES)) u_fwd_src2 (
      .valid(valid_r), .ready(ready_r), .reg_rw(reg_rw_r),
      .dest(dest_r), .result(result_r),
      .read_ptr(read_ptr_r), .ticket(fwd_ticket_in), .rs(fwd_rs2_in),
      .hit(fwd_src2_hit_out), .ready_out(fwd_src2_ready_out), .value(fwd_src2_out)
   );

endmodule
